// File: rtl/axis_pkt_gen_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axis_pkt_gen_if : AXI4-Stream bundle (tdata/tvalid/tlast/tready)            |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
interface axis_pkt_gen_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    output tready
  );
endinterface
`default_nettype wire

// File: rtl/axis_pkt_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | axis_pkt_gen : AXI4-Stream packet transmitter, incrementing data pattern    |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module axis_pkt_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  wire logic                  clk_i,
  input  wire logic                  rst_i,
  input  wire logic                  start_i,
  input  wire logic [LEN_WIDTH-1:0]  pkt_len_i,
  input  wire logic [LEN_WIDTH-1:0]  num_pkts_i,
  input  wire logic [LEN_WIDTH-1:0]  gap_i,
  input  wire logic [DATA_WIDTH-1:0] seed_i,
  output logic                       busy_o,
  output logic                       done_o,
  axis_pkt_gen_if.master             m_axis
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] DATA_ONE = DATA_WIDTH'(1);

  state_t                state_q,     state_d;
  logic [LEN_WIDTH-1:0]  len_q,       len_d;
  logic [LEN_WIDTH-1:0]  gap_q,       gap_d;
  logic [LEN_WIDTH-1:0]  beat_q,      beat_d;
  logic [LEN_WIDTH-1:0]  pkts_left_q, pkts_left_d;
  logic [LEN_WIDTH-1:0]  gap_cnt_q,   gap_cnt_d;
  logic [DATA_WIDTH-1:0] tdata_q,     tdata_d;
  logic                  tvalid_q,    tvalid_d;
  logic                  tlast_q,     tlast_d;
  logic                  busy_q,      busy_d;
  logic                  done_q,      done_d;
  logic                  handshake;
  logic                  start_ok;

  assign handshake = tvalid_q & m_axis.tready;
  assign start_ok  = start_i & (pkt_len_i != '0) & (num_pkts_i != '0);

  // pkts_left counts packets still to follow the one currently on the bus.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    gap_d       = gap_q;
    beat_d      = beat_q;
    pkts_left_d = pkts_left_q;
    gap_cnt_d   = gap_cnt_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d     = ST_SEND;
          len_d       = pkt_len_i;
          gap_d       = gap_i;
          beat_d      = '0;
          pkts_left_d = num_pkts_i - LEN_ONE;
          gap_cnt_d   = '0;
          tdata_d     = seed_i;
          tvalid_d    = 1'b1;
          tlast_d     = (pkt_len_i == LEN_ONE);
          busy_d      = 1'b1;
        end
      end

      ST_SEND: begin
        if (handshake) begin
          tdata_d = tdata_q + DATA_ONE;
          if (tlast_q) begin
            beat_d = '0;
            if (pkts_left_q == '0) begin
              state_d  = ST_IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              busy_d   = 1'b0;
              done_d   = 1'b1;
            end else begin
              pkts_left_d = pkts_left_q - LEN_ONE;
              if (gap_q == '0) begin
                tlast_d = (len_q == LEN_ONE);
              end else begin
                state_d   = ST_GAP;
                gap_cnt_d = gap_q;
                tvalid_d  = 1'b0;
                tlast_d   = 1'b0;
              end
            end
          end else begin
            beat_d  = beat_q + LEN_ONE;
            tlast_d = ((beat_q + LEN_ONE) == (len_q - LEN_ONE));
          end
        end
      end

      ST_GAP: begin
        // gap_cnt holds the idle cycles remaining including the current one.
        if (gap_cnt_q <= LEN_ONE) begin
          state_d   = ST_SEND;
          gap_cnt_d = '0;
          tvalid_d  = 1'b1;
          tlast_d   = (len_q == LEN_ONE);
        end else begin
          gap_cnt_d = gap_cnt_q - LEN_ONE;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      gap_q       <= '0;
      beat_q      <= '0;
      pkts_left_q <= '0;
      gap_cnt_q   <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      beat_q      <= beat_d;
      pkts_left_q <= pkts_left_d;
      gap_cnt_q   <= gap_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
`default_nettype wire
